// File: rtl/port_toggle_responder_pkg.sv
// Shared types and constants for the toggle req/ack memory-port responder.
// This package also provides the address range test used for port and CPU accesses.
package port_toggle_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } resp_state_e;

    localparam logic [15:0] OOR_DATA = 16'hFFFF;

    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/port_toggle_responder.sv
// Serves toggle-handshake read/write requests and a free-running CPU read port from one shared RAM.
// cpu_q follows the cpu_addr sampling edge by RD_LAT+1 clocks; request cycles steal CPU slots.
module port_toggle_responder
    import port_toggle_responder_pkg::*;
#(
    parameter int          AW     = 15,
    parameter int unsigned DEPTH  = 32768,
    parameter int          RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic [15:0]   port_q,
    input  logic [AW-1:0] cpu_addr,
    output logic [15:0]   cpu_q,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    resp_state_e   state;
    logic [AW-1:0] a_lat;
    logic          we_lat;
    logic          oor_lat;
    logic [1:0]    wait_cnt;
    logic          pending;
    logic          port_oor;
    logic          cpu_oor;
    logic          wait_last;
    logic          steal;
    logic [RD_LAT:0] vld_p;
    logic [RD_LAT:0] oor_p;

    assign pending   = port_req != port_ack;
    assign port_oor  = addr_oor(32'(port_a), DEPTH);
    assign cpu_oor   = addr_oor(32'(cpu_addr), DEPTH);
    assign wait_last = wait_cnt == 2'(RD_LAT - 1);

    // High when the next mem_addr belongs to the request path rather than the CPU
    assign steal = (state == IDLE  && pending) ||
                   (state == ISSUE && !we_lat) ||
                   (state == WAIT  && !wait_last);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            port_ack  <= 1'b0;
            port_q    <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_wdata <= '0;
            a_lat     <= '0;
            we_lat    <= 1'b0;
            oor_lat   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            mem_addr <= cpu_addr;
            mem_we   <= 1'b0;
            mem_be   <= 2'b00;
            case (state)
                IDLE: begin
                    if (pending) begin
                        a_lat    <= port_a;
                        we_lat   <= port_we;
                        oor_lat  <= port_oor;
                        mem_addr <= port_a;
                        if (port_we && !port_oor) begin
                            mem_we    <= 1'b1;
                            mem_be    <= port_ds;
                            mem_wdata <= port_d;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_lat) begin
                        state <= DONE;
                    end else begin
                        mem_addr <= a_lat;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_last) begin
                        port_q <= oor_lat ? OOR_DATA : mem_rdata;
                        state  <= DONE;
                    end else begin
                        mem_addr <= a_lat;
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                DONE: begin
                    port_ack <= ~port_ack;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU slot pipeline: bit 0 travels with mem_addr, bit RD_LAT lines up with mem_rdata
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
            oor_p <= '0;
            cpu_q <= '0;
        end else begin
            vld_p <= {vld_p[RD_LAT-1:0], ~steal};
            oor_p <= {oor_p[RD_LAT-1:0], cpu_oor};
            if (vld_p[RD_LAT]) begin
                cpu_q <= oor_p[RD_LAT] ? OOR_DATA : mem_rdata;
            end
        end
    end

endmodule
